// File: rtl/clk_dly_sel_pkg.sv
// Shared types and helpers for the 16-tap clock delay select controller.
// therm() is the reference thermometer encoding used by the RTL and its checker.
package clk_dly_sel_pkg;

  localparam int unsigned DLY_NSEL = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } dly_state_e;

  // Bit i is set iff i < lvl; levels above DLY_NSEL saturate to all ones.
  function automatic logic [DLY_NSEL-1:0] therm(input int unsigned lvl);
    logic [DLY_NSEL-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < DLY_NSEL; i++) begin
      v[i] = (i < lvl);
    end
    return v;
  endfunction

endpackage

// File: rtl/clk_dly_therm_step.sv
// Registered thermometer select and level; each inc/dec strobe moves the level one tap
// and flips exactly one select bit.
module clk_dly_therm_step
  import clk_dly_sel_pkg::*;
#(
  parameter int unsigned NSEL    = DLY_NSEL,
  parameter int unsigned LW      = $clog2(NSEL + 1),
  parameter int unsigned RST_LVL = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [NSEL-1:0] rsel_o,
  output logic [LW-1:0]   lvl_o
);

  localparam logic [DLY_NSEL-1:0] RstFull = therm(RST_LVL);
  localparam logic [NSEL-1:0]     RstSel  = RstFull[NSEL-1:0];
  localparam logic [LW-1:0]       RstLvl  = LW'(RST_LVL);

  logic [NSEL-1:0] rsel_d, rsel_q;
  logic [LW-1:0]   lvl_d, lvl_q;

  // The controller never strobes past the ends, so no wrap guard is needed here.
  always_comb begin
    rsel_d = rsel_q;
    lvl_d  = lvl_q;
    if (inc_i) begin
      rsel_d[lvl_q] = 1'b1;
      lvl_d         = lvl_q + 1'b1;
    end else if (dec_i) begin
      rsel_d[lvl_q - 1'b1] = 1'b0;
      lvl_d                = lvl_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsel_q <= RstSel;
      lvl_q  <= RstLvl;
    end else begin
      rsel_q <= rsel_d;
      lvl_q  <= lvl_d;
    end
  end

  assign rsel_o = rsel_q;
  assign lvl_o  = lvl_q;

endmodule

// File: rtl/clk_16delay_sel_ctrl.sv
// Delay-cell select controller: accepts a target level and ramps the thermometer select
// toward it one tap at a time, holding each tap for a settle window.
module clk_16delay_sel_ctrl
  import clk_dly_sel_pkg::*;
#(
  parameter int unsigned NSEL       = DLY_NSEL,
  parameter int unsigned LW         = $clog2(NSEL + 1),
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned RST_LVL    = 0
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [LW-1:0]   req_lvl,
  output logic [NSEL-1:0] rsel,
  output logic [LW-1:0]   cur_lvl,
  output logic            busy,
  output logic            done,
  output logic            sat
);

  localparam int unsigned   CntW   = 8;
  localparam logic [LW-1:0] MaxLvl = LW'(NSEL);
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYC - 1);

  dly_state_e      state_d, state_q;
  logic [LW-1:0]   tgt_d, tgt_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            sat_d, sat_q;
  logic            ready_d, ready_q;
  logic            busy_d, busy_q;
  logic            done_d, done_q;
  logic [LW-1:0]   clamp_lvl;
  logic            inc, dec;

  clk_dly_therm_step #(
    .NSEL    (NSEL),
    .LW      (LW),
    .RST_LVL (RST_LVL)
  ) u_therm_step (
    .clk_i  (clk),
    .rst_ni (rst_b),
    .inc_i  (inc),
    .dec_i  (dec),
    .rsel_o (rsel),
    .lvl_o  (cur_lvl)
  );

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    inc       = 1'b0;
    dec       = 1'b0;
    clamp_lvl = (req_lvl > MaxLvl) ? MaxLvl : req_lvl;
    unique case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          tgt_d   = clamp_lvl;
          sat_d   = (req_lvl > MaxLvl);
          state_d = (clamp_lvl == cur_lvl) ? DONE : STEP;
        end
      end
      STEP: begin
        if (tgt_q > cur_lvl) begin
          inc = 1'b1;
        end else begin
          dec = 1'b1;
        end
        cnt_d   = CntLoad;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = (cur_lvl == tgt_q) ? DONE : STEP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status outputs are registered from the next state so they line up with it.
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      tgt_q   <= LW'(RST_LVL);
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sat       = sat_q;

  logic [DLY_NSEL-1:0] rsel_ref;
  assign rsel_ref = therm(32'(cur_lvl));

  a_rsel_therm : assert property (@(posedge clk) disable iff (!rst_b)
    rsel == rsel_ref[NSEL-1:0]);

  a_rsel_only_in_step : assert property (@(posedge clk) disable iff (!rst_b)
    (state_q != STEP) |=> $stable(rsel));

endmodule

// File: tb/tb_clk_16delay_sel_ctrl.sv
// Directed bench for clk_16delay_sel_ctrl: default instance (NSEL=15, SETTLE_CYC=4) plus a
// NSEL=14, SETTLE_CYC=1 instance for the clamp/saturation case.
module tb_clk_16delay_sel_ctrl;

  localparam int Settle = 4;
  localparam int Per    = Settle + 1;

  logic        clk;
  logic        rst_b;
  logic        req_valid, req_ready;
  logic [3:0]  req_lvl;
  logic [14:0] rsel;
  logic [3:0]  cur_lvl;
  logic        busy, done, sat;

  logic        req_valid14, req_ready14;
  logic [3:0]  req_lvl14;
  logic [13:0] rsel14;
  logic [3:0]  cur_lvl14;
  logic        busy14, done14, sat14;

  int n_checks;
  int n_errors;

  clk_16delay_sel_ctrl #(
    .NSEL       (15),
    .LW         (4),
    .SETTLE_CYC (Settle),
    .RST_LVL    (0)
  ) u_dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_lvl   (req_lvl),
    .rsel      (rsel),
    .cur_lvl   (cur_lvl),
    .busy      (busy),
    .done      (done),
    .sat       (sat)
  );

  clk_16delay_sel_ctrl #(
    .NSEL       (14),
    .LW         (4),
    .SETTLE_CYC (1),
    .RST_LVL    (0)
  ) u_dut14 (
    .clk       (clk),
    .rst_b     (rst_b),
    .req_valid (req_valid14),
    .req_ready (req_ready14),
    .req_lvl   (req_lvl14),
    .rsel      (rsel14),
    .cur_lvl   (cur_lvl14),
    .busy      (busy14),
    .done      (done14),
    .sat       (sat14)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rsel(input int lvl);
    return (32'd1 << lvl) - 32'd1;
  endfunction

  // Issue a request from level 'from' to 'to' and check every cycle until back in IDLE.
  // Starts and ends just after a falling edge with the DUT idle. With 'hold' set, req_valid
  // stays high carrying hold_lvl for the whole ramp.
  task automatic ramp(input int from, input int to, input bit hold, input int hold_lvl);
    int d, dir, steps, lvl_exp, last;
    logic [14:0] prev;
    d    = (to > from) ? to - from : from - to;
    dir  = (to > from) ? 1 : -1;
    last = d * Per;
    check($sformatf("ready_pre %0d->%0d", from, to), req_ready, 1);
    req_valid = 1'b1;
    req_lvl   = 4'(to);
    prev      = rsel;
    @(posedge clk);
    for (int e = 0; e <= last + 1; e++) begin
      @(negedge clk);
      if (e == 0) begin
        if (hold) req_lvl = 4'(hold_lvl);
        else      req_valid = 1'b0;
      end
      steps   = (e == 0) ? 0 : (e - 1) / Per + 1;
      if (steps > d) steps = d;
      lvl_exp = from + dir * steps;
      check($sformatf("rsel %0d->%0d e%0d", from, to, e), 32'(rsel), exp_rsel(lvl_exp));
      check($sformatf("cur_lvl %0d->%0d e%0d", from, to, e), 32'(cur_lvl), lvl_exp);
      check($sformatf("one_bit %0d->%0d e%0d", from, to, e),
            32'($countones(rsel ^ prev) <= 1), 1);
      check($sformatf("done %0d->%0d e%0d", from, to, e), done, e == last);
      check($sformatf("busy %0d->%0d e%0d", from, to, e), busy, e <= last);
      check($sformatf("ready %0d->%0d e%0d", from, to, e), req_ready, e == last + 1);
      prev = rsel;
    end
  endtask

  initial begin
    int cyc;
    n_checks    = 0;
    n_errors    = 0;
    rst_b       = 1'b0;
    req_valid   = 1'b0;
    req_lvl     = '0;
    req_valid14 = 1'b0;
    req_lvl14   = '0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    check("rst_rsel", 32'(rsel), 32'h0000);
    check("rst_cur_lvl", 32'(cur_lvl), 0);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat, 0);

    // 0 -> 3: taps land at edges 1, 6, 11; done at edge 15 (16th cycle counting accept).
    ramp(0, 3, 1'b0, 0);
    ramp(3, 15, 1'b0, 0);
    check("sat_after_15", sat, 0);
    ramp(15, 0, 1'b0, 0);
    ramp(0, 9, 1'b0, 0);
    ramp(9, 9, 1'b0, 0);
    ramp(9, 0, 1'b0, 0);
    // A request for 5 held throughout the 0 -> 15 ramp is only taken once idle.
    ramp(0, 15, 1'b1, 5);
    ramp(15, 5, 1'b0, 0);

    // Reset mid-ramp: 5 -> 12, first tap reaches 6, then drop rst_b inside the settle window.
    req_valid = 1'b1;
    req_lvl   = 4'd12;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_lvl", 32'(cur_lvl), 6);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("mid_rst_rsel", 32'(rsel), 32'h0000);
    check("mid_rst_cur_lvl", 32'(cur_lvl), 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_done c%0d", i), done, 0);
    end
    check("post_rst_rsel", 32'(rsel), 32'h0000);
    check("post_rst_busy", busy, 0);

    // NSEL=14 instance: 4'hF clamps to 14 and sets sat; two cycles per tap.
    check("n14_sat_rst", sat14, 0);
    req_valid14 = 1'b1;
    req_lvl14   = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid14 = 1'b0;
    check("n14_sat_set", sat14, 1);
    check("n14_busy", busy14, 1);
    cyc = 0;
    while (!done14 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("n14_lat_up", 32'(cyc), 28);
    check("n14_lvl_up", 32'(cur_lvl14), 14);
    check("n14_rsel_up", 32'(rsel14), 32'h3FFF);
    check("n14_sat_hold", sat14, 1);
    @(negedge clk);
    check("n14_ready", req_ready14, 1);
    req_valid14 = 1'b1;
    req_lvl14   = 4'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid14 = 1'b0;
    check("n14_sat_clr", sat14, 0);
    cyc = 0;
    while (!done14 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("n14_lat_dn", 32'(cyc), 22);
    check("n14_lvl_dn", 32'(cur_lvl14), 3);
    check("n14_rsel_dn", 32'(rsel14), 32'h0007);
    check("n14_sat_dn", sat14, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
